// File: rtl/seq_mult_8bit.sv
// Sequential 8x8 unsigned shift-add multiplier built around one 8-bit ripple-carry adder.
// Latency: done pulses 8 clocks after the accepting start edge; product registered at that edge.
// Backpressure: start is ignored while busy; a held start re-launches from DONE back-to-back.

// 8-bit ripple-carry adder; carry is kept in a scalar so the chain ripples bit by bit.
module rca_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       c
);
    logic carry;

    // Ripple the carry from bit 0 up to bit 7.
    always_comb begin
        carry = cin;
        s     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c = carry;
    end
endmodule

module seq_mult_8bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  mcand;
    logic [7:0]  acc;
    logic [7:0]  q;
    logic [2:0]  cnt;
    logic [7:0]  sum;
    logic        sum_c;
    logic [15:0] shifted;
    logic        load;

    rca_8bit u_rca (
        .a   (acc),
        .b   (mcand),
        .cin (1'b0),
        .s   (sum),
        .c   (sum_c)
    );

    // A new operation is accepted only when not in the middle of a run.
    assign load = start && ((state == IDLE) || (state == DONE));

    // One shift-add step: add the multiplicand when the current multiplier bit is set,
    // then shift right with the adder carry landing in acc[7].
    always_comb begin
        shifted = {1'b0, acc, q[7:1]};
        if (q[0]) begin
            shifted = {sum_c, sum, q[7:1]};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; RUN ignores start so a run always completes exactly once.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = (cnt == 3'd7) ? DONE : RUN;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, and the final product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= 8'h00;
            acc     <= 8'h00;
            q       <= 8'h00;
            cnt     <= 3'd0;
            product <= 16'h0000;
        end else if (load) begin
            mcand <= a;
            q     <= b;
            acc   <= 8'h00;
            cnt   <= 3'd0;
        end else if (state == RUN) begin
            {acc, q} <= shifted;
            // cnt naturally wraps 7 -> 0 on the exit edge.
            cnt      <= cnt + 3'd1;
            if (cnt == 3'd7) begin
                product <= shifted;
            end
        end
    end

    // Moore outputs.
    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_seq_mult_8bit.sv
// Scoreboarded bench for seq_mult_8bit with directed operand vectors.
// Stimulus pushes expected products; a negedge monitor pops and compares on done.
// Product hold between completions and reset behaviour are checked alongside.
module tb_seq_mult_8bit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;

    int          pass_cnt;
    int          total_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] last_prod;

    seq_mult_8bit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare product on each done, and require it to hold otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("product", 32'(product), 32'(e));
                    last_prod = e;
                end
            end else begin
                chk("product_hold", 32'(product), 32'(last_prod));
            end
        end
    end

    // Launch one operation with a single-cycle start.
    task automatic issue(input logic [7:0] x, input logic [7:0] y, input logic [15:0] e);
        @(negedge clk);
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count negedges until done is seen; also count cycles spent busy.
    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy) nbusy++;
        end while (!done && n < 40);
        if (!done) chk("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int n;
        int nb;
        pass_cnt  = 0;
        total_cnt = 0;
        last_prod = 16'h0000;
        rst_n     = 1'b0;
        start     = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

        #2;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic multiply with latency and busy-width checks.
        issue(8'h0D, 8'h0B, 16'h008F);
        wait_done(n, nb);
        chk("latency_0d_0b", 32'(n), 32'd9);
        chk("busy_cycles", 32'(nb), 32'd8);
        @(negedge clk);
        chk("done_one_pulse", 32'(done), 32'd0);

        // Carry-out into the top bit, and a pure power-of-two shift.
        issue(8'hFF, 8'hFF, 16'hFE01);
        wait_done(n, nb);
        issue(8'h80, 8'h02, 16'h0100);
        wait_done(n, nb);

        // Zero result, then a result that must not appear until completion.
        issue(8'h00, 8'h5A, 16'h0000);
        wait_done(n, nb);
        issue(8'h5A, 8'h01, 16'h005A);
        wait_done(n, nb);

        // Start pulsed mid-run must be ignored.
        issue(8'h03, 8'h05, 16'h000F);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h11;
        @(negedge clk);
        start = 1'b0;
        wait_done(n, nb);
        repeat (12) @(negedge clk);
        chk("no_extra_run", 32'(busy), 32'd0);

        // Back-to-back with start held high through DONE.
        @(negedge clk);
        start = 1'b1;
        a     = 8'h02;
        b     = 8'h03;
        exp_q.push_back(16'h0006);
        wait_done(n, nb);
        chk("b2b_first_latency", 32'(n), 32'd9);
        a = 8'h04;
        b = 8'h05;
        exp_q.push_back(16'h0014);
        wait_done(n, nb);
        chk("b2b_spacing", 32'(n), 32'd9);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_stops", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of 0xFF x 0xFF aborts it.
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        last_prod = 16'h0000;
        rst_n     = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(8'h03, 8'h03, 16'h0009);
        wait_done(n, nb);
        chk("post_reset_latency", 32'(n), 32'd9);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
